next_pc_ctrl: RTL and testbench

Control-side driver for the fetch-stage PC register. Decides each cycle whether the PC advances, holds or redirects, and drives the register's select code, enable and three target buses. It takes resolved control-flow requests from the EX stage and stall status from instruction memory and hazard logic. A redirect that arrives while fetch is stalled is captured, then replayed once the stall clears. The block also squashes the wrong-path instruction and counts taken redirects for performance monitoring.

---
 rtl/next_pc_ctrl_pkg.sv | 25 ++
 rtl/next_pc_ctrl_redirect_prio.sv | 38 +++
 rtl/next_pc_ctrl.sv | 122 ++++++++++++
 tb/tb_next_pc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/next_pc_ctrl_pkg.sv
// Shared CPU constants for the fetch-stage PC path.
//   pc_sel_e   : PC register select codes (PC+4, branch, jump, JR)
//   state_e    : next_pc_ctrl redirect state (RUN, PEND)
//   redirect_t : resolved redirect {valid, kind, target}
package next_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_JR  = 2'b00,
    SEL_BR  = 2'b01,
    SEL_PC4 = 2'b10,
    SEL_JAL = 2'b11
  } pc_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    pc_sel_e     kind;
    logic [31:0] target;
  } redirect_t;

endpackage

// File: rtl/next_pc_ctrl_redirect_prio.sv
// Combinational priority encoder for EX-stage control-flow requests.
// The priority is JR first, then J/JAL, then taken branch.
//   br_taken/br_target   : conditional branch request and target
//   jmp_req/jmp_target   : J/JAL request and target
//   jr_req/jr_target     : JR/JALR request and target
//   redir                : {valid, winning kind, winning target}
module redirect_prio
  import next_pc_ctrl_pkg::*;
(
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  output redirect_t   redir
);

  always_comb begin
    redir.valid  = 1'b0;
    redir.kind   = SEL_PC4;
    redir.target = '0;
    if (jr_req) begin
      redir.valid  = 1'b1;
      redir.kind   = SEL_JR;
      redir.target = jr_target;
    end else if (jmp_req) begin
      redir.valid  = 1'b1;
      redir.kind   = SEL_JAL;
      redir.target = jmp_target;
    end else if (br_taken) begin
      redir.valid  = 1'b1;
      redir.kind   = SEL_BR;
      redir.target = br_target;
    end
  end

endmodule

// File: rtl/next_pc_ctrl.sv
// Fetch-stage PC control: advances, holds or redirects the PC register.
// A redirect that meets an instruction-memory stall is captured and
// replayed on the first unstalled cycle.
//   CLK, RST                 : clock, synchronous active-high reset
//   BrTaken/JmpReq/JrReq     : EX-stage redirect requests
//   BrTarget/JmpTarget/JrTarget : EX-stage redirect targets
//   IMemStall, HazStall      : fetch stall sources
//   PC_Sel, PC_EN            : PC register select code and write enable
//   PC_Branch, PC_JAL, JR    : PC register target buses
//   Flush_IF                 : squash the instruction in IF
//   RedirCount               : applied redirects since reset (wraps)
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        JmpReq,
  input  logic [31:0] JmpTarget,
  input  logic        JrReq,
  input  logic [31:0] JrTarget,
  input  logic        IMemStall,
  input  logic        HazStall,
  output logic [1:0]  PC_Sel,
  output logic        PC_EN,
  output logic [31:0] PC_Branch,
  output logic [31:0] PC_JAL,
  output logic [31:0] JR,
  output logic        Flush_IF,
  output logic [31:0] RedirCount
);

  state_e      state;
  pc_sel_e     pend_kind;
  logic [31:0] pend_target;
  logic [31:0] redir_cnt;
  redirect_t   live;
  pc_sel_e     sel;

  redirect_prio u_prio (
    .br_taken  (BrTaken),
    .br_target (BrTarget),
    .jmp_req   (JmpReq),
    .jmp_target(JmpTarget),
    .jr_req    (JrReq),
    .jr_target (JrTarget),
    .redir     (live)
  );

  always_comb begin
    sel       = SEL_PC4;
    PC_EN     = 1'b0;
    Flush_IF  = 1'b0;
    PC_Branch = BrTarget;
    PC_JAL    = JmpTarget;
    JR        = JrTarget;
    if (!RST) begin
      unique case (state)
        RUN: begin
          if (live.valid) begin
            // A live redirect overrides HazStall; only IMemStall defers it.
            if (!IMemStall) begin
              sel      = live.kind;
              PC_EN    = 1'b1;
              Flush_IF = 1'b1;
            end
          end else begin
            PC_EN = ~(IMemStall | HazStall);
          end
        end
        PEND: begin
          // EX is frozen on the same instruction, so live requests are ignored.
          sel      = pend_kind;
          PC_EN    = ~IMemStall;
          Flush_IF = ~IMemStall;
          unique case (pend_kind)
            SEL_BR:  PC_Branch = pend_target;
            SEL_JAL: PC_JAL    = pend_target;
            SEL_JR:  JR        = pend_target;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign PC_Sel     = sel;
  assign RedirCount = redir_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      pend_kind   <= SEL_PC4;
      pend_target <= '0;
      redir_cnt   <= '0;
    end else begin
      // Flush_IF marks exactly the cycles in which a redirect is applied.
      if (Flush_IF)
        redir_cnt <= redir_cnt + 32'd1;
      unique case (state)
        RUN: begin
          if (live.valid && IMemStall) begin
            state       <= PEND;
            pend_kind   <= live.kind;
            pend_target <= live.target;
          end
        end
        PEND: begin
          if (!IMemStall) begin
            state       <= RUN;
            pend_kind   <= SEL_PC4;
            pend_target <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_ctrl.sv
module tb_next_pc_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        BrTaken, JmpReq, JrReq, IMemStall, HazStall;
  logic [31:0] BrTarget, JmpTarget, JrTarget;
  logic [1:0]  PC_Sel;
  logic        PC_EN, Flush_IF;
  logic [31:0] PC_Branch, PC_JAL, JR, RedirCount;

  int checks = 0;
  int errors = 0;

  next_pc_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .BrTaken   (BrTaken),
    .BrTarget  (BrTarget),
    .JmpReq    (JmpReq),
    .JmpTarget (JmpTarget),
    .JrReq     (JrReq),
    .JrTarget  (JrTarget),
    .IMemStall (IMemStall),
    .HazStall  (HazStall),
    .PC_Sel    (PC_Sel),
    .PC_EN     (PC_EN),
    .PC_Branch (PC_Branch),
    .PC_JAL    (PC_JAL),
    .JR        (JR),
    .Flush_IF  (Flush_IF),
    .RedirCount(RedirCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        jr;
    logic [31:0] jrt;
    logic        imem;
    logic        haz;
    logic [1:0]  exp_sel;
    logic        exp_en;
    logic        exp_flush;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] brt, input logic jmp,
                       input logic [31:0] jmpt, input logic jr, input logic [31:0] jrt,
                       input logic imem, input logic haz);
    BrTaken = br;  BrTarget = brt;
    JmpReq  = jmp; JmpTarget = jmpt;
    JrReq   = jr;  JrTarget = jrt;
    IMemStall = imem; HazStall = haz;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // RUN-state vectors; buses must pass the live targets through.
    //           br  brt     jmp jmpt    jr  jrt     imem haz  sel    en   fl   cnt
    vecs[0] = '{1'b0, 32'h11, 1'b0, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 32'd0};
    vecs[1] = '{1'b1, 32'h40, 1'b0, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'd1};
    vecs[2] = '{1'b0, 32'h40, 1'b0, 32'h22, 1'b0, 32'h33, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'd1};
    vecs[3] = '{1'b0, 32'h40, 1'b1, 32'h200, 1'b0, 32'h33, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 32'd2};
    vecs[4] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'd3};
    vecs[5] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h300, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 32'd4};
    vecs[6] = '{1'b0, 32'h100, 1'b0, 32'h200, 1'b0, 32'h300, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'd4};
    vecs[7] = '{1'b0, 32'h100, 1'b0, 32'h200, 1'b1, 32'h304, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'd5};

    // Reset, with a request present that reset must override.
    RST = 1'b1;
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_pc_en", {31'b0, PC_EN}, 32'd0);
    chk("rst_pc_sel", {30'b0, PC_Sel}, 32'd2);
    chk("rst_flush", {31'b0, Flush_IF}, 32'd0);
    chk("rst_cnt", RedirCount, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    chk("rel_pc_en", {31'b0, PC_EN}, 32'd1);
    chk("rel_pc_sel", {30'b0, PC_Sel}, 32'd2);
    chk("rel_cnt", RedirCount, 32'd0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jmpt,
            vecs[i].jr, vecs[i].jrt, vecs[i].imem, vecs[i].haz);
      #1;
      chk($sformatf("v%0d_sel", i), {30'b0, PC_Sel}, {30'b0, vecs[i].exp_sel});
      chk($sformatf("v%0d_en", i), {31'b0, PC_EN}, {31'b0, vecs[i].exp_en});
      chk($sformatf("v%0d_flush", i), {31'b0, Flush_IF}, {31'b0, vecs[i].exp_flush});
      chk($sformatf("v%0d_pcbr", i), PC_Branch, vecs[i].brt);
      chk($sformatf("v%0d_pcjal", i), PC_JAL, vecs[i].jmpt);
      chk($sformatf("v%0d_jr", i), JR, vecs[i].jrt);
      tick();
      chk($sformatf("v%0d_cnt", i), RedirCount, vecs[i].exp_cnt);
    end

    // Stalled JR: captured target must survive a changing JrTarget.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
    #1;
    chk("stl1_en", {31'b0, PC_EN}, 32'd0);
    chk("stl1_flush", {31'b0, Flush_IF}, 32'd0);
    tick();
    JrTarget = 32'hDEAD;
    HazStall = 1'b1;
    #1;
    chk("stl2_en", {31'b0, PC_EN}, 32'd0);
    chk("stl2_flush", {31'b0, Flush_IF}, 32'd0);
    chk("stl2_jr", JR, 32'h1000);
    tick();
    HazStall = 1'b0;
    #1;
    chk("stl3_en", {31'b0, PC_EN}, 32'd0);
    chk("stl3_cnt", RedirCount, 32'd5);
    tick();
    IMemStall = 1'b0;
    HazStall  = 1'b1;
    #1;
    chk("replay_sel", {30'b0, PC_Sel}, 32'd0);
    chk("replay_en", {31'b0, PC_EN}, 32'd1);
    chk("replay_flush", {31'b0, Flush_IF}, 32'd1);
    chk("replay_jr", JR, 32'h1000);
    tick();
    chk("replay_cnt", RedirCount, 32'd6);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h77, 1'b0, 1'b0);
    #1;
    chk("post_sel", {30'b0, PC_Sel}, 32'd2);
    chk("post_flush", {31'b0, Flush_IF}, 32'd0);
    chk("post_jr", JR, 32'h77);
    tick();
    chk("post_cnt", RedirCount, 32'd6);

    // Reset while a branch redirect is pending discards it.
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    RST = 1'b1;
    #1;
    chk("prst_en", {31'b0, PC_EN}, 32'd0);
    chk("prst_sel", {30'b0, PC_Sel}, 32'd2);
    tick();
    RST = 1'b0;
    drive(1'b0, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("prst_run_sel", {30'b0, PC_Sel}, 32'd2);
    chk("prst_run_en", {31'b0, PC_EN}, 32'd1);
    chk("prst_run_flush", {31'b0, Flush_IF}, 32'd0);
    chk("prst_run_pcbr", PC_Branch, 32'h600);
    chk("prst_cnt", RedirCount, 32'd0);
    tick();

    // Counter wrap.
    force dut.redir_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.redir_cnt;
    #1;
    chk("wrap_pre", RedirCount, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("wrap_flush", {31'b0, Flush_IF}, 32'd1);
    tick();
    chk("wrap_cnt", RedirCount, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
